// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared types, defaults and helpers for the multiplier scheduler
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  localparam int NREQ_DEF    = 4;
  localparam int WIDTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 32;

  // Round-robin pointer that follows the requester just served.
  function automatic int next_rr(input int owner, input int nreq);
    return (owner + 1 >= nreq) ? 0 : owner + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  // Scan requesters from rr_ptr upward, wrapping at NREQ; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      j = sum[IW-1:0];
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - time-shares one multiplier core among NREQ requesters
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic [2*WIDTH-1:0]    resp_product,
  output logic                  resp_err,
  input  logic                  resp_ready,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_product,
  input  logic                  mul_done,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_t       state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] result;
  logic               err;
  logic [CW-1:0]      count;

  logic [NREQ-1:0]    pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // No transfer can happen on a reset edge, so the accept strobe is masked by rst.
  assign req_ready    = (state == IDLE && !rst) ? pick_grant : '0;
  assign busy         = (state != IDLE);
  assign mul_a        = op_a;
  assign mul_b        = op_b;
  assign resp_product = result;
  assign resp_err     = err;

  // Scheduler FSM: accept, start the core, wait with watchdog, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      err        <= 1'b0;
      count      <= '0;
      mul_start  <= 1'b0;
      resp_valid <= '0;
    end else begin
      mul_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            op_a      <= req_a[int'(pick_idx)*WIDTH +: WIDTH];
            op_b      <= req_b[int'(pick_idx)*WIDTH +: WIDTH];
            owner     <= pick_idx;
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A completion in the final watchdog cycle still counts as success.
          if (mul_done) begin
            result     <= mul_product;
            err        <= 1'b0;
            resp_valid <= NREQ'(1) << owner;
            state      <= RESP;
          end else if (count == CW'(TIMEOUT - 1)) begin
            result     <= '0;
            err        <= 1'b1;
            resp_valid <= NREQ'(1) << owner;
            state      <= RESP;
          end else begin
            count <= count + CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= '0;
            rr_ptr     <= IW'(next_rr(int'(owner), NREQ));
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - self-checking bench for mult_share_sched
module tb_mult_share_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [15:0] resp_product;
  logic        resp_err;
  logic        resp_ready = 1'b0;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_product;
  logic        mul_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] opa [4];
  logic [7:0] opb [4];

  // core model: fixed latency, core_lat == 0 means it never finishes
  int         core_lat = 17;
  int         core_cnt = 0;
  logic       core_active = 1'b0;
  logic [7:0] ca = '0;
  logic [7:0] cb = '0;
  logic       stray_done = 1'b0;
  logic       core_done;

  always #5 clk = ~clk;

  // cycle counter used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // multiplier core stand-in sharing the scheduler reset
  always @(posedge clk) begin
    if (rst) begin
      core_active <= 1'b0;
      core_cnt    <= 0;
    end else if (mul_start) begin
      core_active <= 1'b1;
      core_cnt    <= 1;
      ca          <= mul_a;
      cb          <= mul_b;
    end else if (core_active) begin
      if (core_done) core_active <= 1'b0;
      else core_cnt <= core_cnt + 1;
    end
  end

  assign core_done   = core_active && (core_lat != 0) && (core_cnt == core_lat);
  assign mul_done    = core_done | stray_done;
  assign mul_product = core_done ? 16'(ca) * 16'(cb) : 16'hDEAD;

  mult_share_sched #(.NREQ(4), .WIDTH(8), .TIMEOUT(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .resp_err     (resp_err),
    .resp_ready   (resp_ready),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_product  (mul_product),
    .mul_done     (mul_done),
    .busy         (busy)
  );

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'(a) * int'(b);
    return 16'(p);
  endfunction

  task automatic pack_ops();
    req_a = {opa[3], opa[2], opa[1], opa[0]};
    req_b = {opb[3], opb[2], opb[1], opb[0]};
  endtask

  task automatic cyc_adv();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    #1;
    for (int n = 0; n < 100; n++) begin
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        return;
      end
      cyc_adv();
      #1;
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    #1;
    for (int n = 0; n < 200; n++) begin
      if (resp_valid != 4'b0) begin
        ok = 1'b1;
        return;
      end
      cyc_adv();
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'hF;
    resp_ready = 1'b0;
    repeat (2) cyc_adv();
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0000", resp_valid); end
    checks++; if (resp_product !== 16'h0) begin errors++; $display("FAIL reset_resp_product got %h want 0000", resp_product); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start got %b want 0", mul_start); end
    checks++; if (mul_a !== 8'h0 || mul_b !== 8'h0) begin errors++; $display("FAIL reset_mul_ab got %h/%h want 00/00", mul_a, mul_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    #2;
  endtask

  task automatic test_single();
    bit ok;
    int tg;
    opa[2] = 8'hFF; opb[2] = 8'hFF; pack_ops();
    req_valid = 4'b0100;
    resp_ready = 1'b1;
    wait_grant(ok);
    tg = cyc;
    checks++; if (!ok || req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_ready); end
    cyc_adv();
    req_valid = '0;
    #1;
    checks++; if (mul_start !== 1'b1 || mul_a !== 8'hFF || mul_b !== 8'hFF) begin errors++; $display("FAIL single_start got %b %h %h want 1 ff ff", mul_start, mul_a, mul_b); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    wait_resp(ok);
    checks++; if (!ok || cyc - tg != 19) begin errors++; $display("FAIL single_latency got %0d want 19", cyc - tg); end
    checks++; if (resp_valid !== 4'b0100 || resp_product !== 16'hFE01 || resp_err !== 1'b0) begin errors++; $display("FAIL single_resp got %b %h %b want 0100 fe01 0", resp_valid, resp_product, resp_err); end
    cyc_adv();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy %b want 0", busy); end
  endtask

  task automatic test_fairness();
    bit ok;
    int ptr, e, tg, last_resp;
    logic [15:0] ep;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      opa[i] = 8'($urandom_range(0, 255));
      opb[i] = 8'($urandom_range(0, 255));
    end
    opa[0] = 8'h12; opb[0] = 8'h34; pack_ops();
    req_valid = 4'hF;
    resp_ready = 1'b1;
    ptr = 0;
    last_resp = -1;
    for (int it = 0; it < 5; it++) begin
      wait_grant(ok);
      e = pick(4'hF, ptr);
      tg = cyc;
      checks++; if (!ok || req_ready !== 4'(1 << e)) begin errors++; $display("FAIL fair_grant it=%0d got %b want %b", it, req_ready, 4'(1 << e)); end
      if (last_resp >= 0) begin
        checks++; if (tg - last_resp != 1) begin errors++; $display("FAIL back_to_back gap got %0d want 1", tg - last_resp); end
      end
      ep = ref_mul(opa[e], opb[e]);
      cyc_adv();
      opa[e] = 8'($urandom_range(0, 255));
      opb[e] = 8'($urandom_range(0, 255));
      pack_ops();
      wait_resp(ok);
      checks++; if (!ok || resp_valid !== 4'(1 << e) || resp_product !== ep || resp_err !== 1'b0) begin errors++; $display("FAIL fair_resp it=%0d got %b %h %b want %b %h 0", it, resp_valid, resp_product, resp_err, 4'(1 << e), ep); end
      checks++; if (cyc - tg != 19) begin errors++; $display("FAIL fair_latency it=%0d got %0d want 19", it, cyc - tg); end
      last_resp = cyc;
      ptr = (e + 1) % 4;
      cyc_adv();
    end
    req_valid = '0;
    wait_grant(ok);
    cyc_adv();
    wait_resp(ok);
    cyc_adv();
  endtask

  task automatic test_backpressure();
    bit ok;
    int r, e;
    logic [3:0]  rv;
    logic [15:0] rp, ep;
    logic        re;
    r = $urandom_range(0, 3);
    opa[r] = 8'($urandom_range(0, 255)); opb[r] = 8'($urandom_range(0, 255)); pack_ops();
    ep = ref_mul(opa[r], opb[r]);
    resp_ready = 1'b0;
    req_valid = 4'(1 << r);
    wait_grant(ok);
    checks++; if (!ok || req_ready !== 4'(1 << r)) begin errors++; $display("FAIL bp_grant got %b want %b", req_ready, 4'(1 << r)); end
    cyc_adv();
    req_valid = '0;
    wait_resp(ok);
    checks++; if (!ok || resp_product !== ep || resp_err !== 1'b0) begin errors++; $display("FAIL bp_resp got %h %b want %h 0", resp_product, resp_err, ep); end
    rv = resp_valid; rp = resp_product; re = resp_err;
    for (int i = 0; i < 10; i++) begin
      cyc_adv();
      req_valid = 4'hF;
      #1;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_req_ready i=%0d got %b want 0000", i, req_ready); end
      checks++; if (resp_valid !== rv || resp_product !== rp || resp_err !== re) begin errors++; $display("FAIL bp_stable i=%0d got %b %h %b want %b %h %b", i, resp_valid, resp_product, resp_err, rv, rp, re); end
    end
    cyc_adv();
    resp_ready = 1'b1;
    cyc_adv();
    #1;
    e = pick(4'hF, (r + 1) % 4);
    checks++; if (req_ready !== 4'(1 << e)) begin errors++; $display("FAIL bp_next_grant got %b want %b", req_ready, 4'(1 << e)); end
    ep = ref_mul(opa[e], opb[e]);
    cyc_adv();
    req_valid = '0;
    wait_resp(ok);
    checks++; if (!ok || resp_valid !== 4'(1 << e) || resp_product !== ep) begin errors++; $display("FAIL bp_next_resp got %b %h want %b %h", resp_valid, resp_product, 4'(1 << e), ep); end
    cyc_adv();
  endtask

  task automatic test_timeout();
    bit ok;
    int ts;
    logic [15:0] ep;
    core_lat = 0;
    opa[1] = 8'($urandom_range(1, 255)); opb[1] = 8'($urandom_range(1, 255)); pack_ops();
    resp_ready = 1'b1;
    req_valid = 4'b0010;
    wait_grant(ok);
    cyc_adv();
    req_valid = '0;
    #1;
    ts = cyc;
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL to_start got %b want 1", mul_start); end
    wait_resp(ok);
    checks++; if (!ok || cyc - ts != 33) begin errors++; $display("FAIL to_latency got %0d want 33", cyc - ts); end
    checks++; if (resp_valid !== 4'b0010 || resp_err !== 1'b1 || resp_product !== 16'h0) begin errors++; $display("FAIL to_resp got %b %b %h want 0010 1 0000", resp_valid, resp_err, resp_product); end
    core_lat = 17;
    cyc_adv();
    req_valid = 4'hF;
    wait_grant(ok);
    checks++; if (!ok || req_ready !== 4'b0100) begin errors++; $display("FAIL to_rr_advance got %b want 0100", req_ready); end
    ep = ref_mul(opa[2], opb[2]);
    cyc_adv();
    req_valid = '0;
    wait_resp(ok);
    checks++; if (!ok || resp_product !== ep || resp_err !== 1'b0) begin errors++; $display("FAIL to_recover got %h %b want %h 0", resp_product, resp_err, ep); end
    cyc_adv();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int tg;
    logic [15:0] ep;
    opa[3] = 8'($urandom_range(1, 255)); opb[3] = 8'($urandom_range(1, 255)); pack_ops();
    resp_ready = 1'b1;
    req_valid = 4'b1000;
    wait_grant(ok);
    cyc_adv();
    req_valid = '0;
    repeat (6) cyc_adv();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got %b want 1", busy); end
    rst = 1'b1;
    cyc_adv();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || mul_start !== 1'b0 || resp_valid !== 4'b0) begin errors++; $display("FAIL rm_ctrl got busy %b start %b rv %b want 0 0 0000", busy, mul_start, resp_valid); end
    checks++; if (resp_product !== 16'h0 || resp_err !== 1'b0 || mul_a !== 8'h0 || mul_b !== 8'h0) begin errors++; $display("FAIL rm_data got %h %b %h %h want 0000 0 00 00", resp_product, resp_err, mul_a, mul_b); end
    cyc_adv();
    stray_done = 1'b1;
    cyc_adv();
    stray_done = 1'b0;
    cyc_adv();
    #1;
    checks++; if (busy !== 1'b0 || resp_valid !== 4'b0) begin errors++; $display("FAIL rm_stray got busy %b rv %b want 0 0000", busy, resp_valid); end
    opa[0] = 8'($urandom_range(0, 255)); opb[0] = 8'($urandom_range(0, 255)); pack_ops();
    ep = ref_mul(opa[0], opb[0]);
    cyc_adv();
    req_valid = 4'b0001;
    wait_grant(ok);
    tg = cyc;
    checks++; if (!ok || req_ready !== 4'b0001) begin errors++; $display("FAIL rm_grant got %b want 0001", req_ready); end
    cyc_adv();
    req_valid = '0;
    wait_resp(ok);
    checks++; if (!ok || cyc - tg != 19 || resp_valid !== 4'b0001 || resp_product !== ep || resp_err !== 1'b0) begin errors++; $display("FAIL rm_resp got lat %0d %b %h %b want 19 0001 %h 0", cyc - tg, resp_valid, resp_product, resp_err, ep); end
    cyc_adv();
  endtask

  task automatic test_edges();
    bit ok;
    int r, tg;
    logic [15:0] ep;
    int          lats [3];
    logic [7:0]  ea [3];
    logic [7:0]  eb [3];
    lats[0] = 17; ea[0] = 8'h00; eb[0] = 8'hAB;
    lats[1] = 17; ea[1] = 8'h80; eb[1] = 8'h02;
    lats[2] = 32; ea[2] = 8'($urandom_range(1, 255)); eb[2] = 8'($urandom_range(1, 255));
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_lat = lats[i];
      r = $urandom_range(0, 3);
      opa[r] = ea[i]; opb[r] = eb[i]; pack_ops();
      ep = ref_mul(ea[i], eb[i]);
      req_valid = 4'(1 << r);
      wait_grant(ok);
      tg = cyc;
      cyc_adv();
      req_valid = '0;
      wait_resp(ok);
      checks++; if (!ok || resp_product !== ep || resp_err !== 1'b0 || resp_valid !== 4'(1 << r)) begin errors++; $display("FAIL edge%0d got %b %h %b want %b %h 0", i, resp_valid, resp_product, resp_err, 4'(1 << r), ep); end
      checks++; if (cyc - tg != lats[i] + 2) begin errors++; $display("FAIL edge%0d_latency got %0d want %0d", i, cyc - tg, lats[i] + 2); end
      cyc_adv();
    end
    core_lat = 17;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench did not finish");
  end

endmodule
